bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// A conversion takes M shift cycles plus one cycle to publish the result.
// The result and its leading-zero blanking mask stay stable between conversions.
//
// Handshake: start is level-sensitive and is accepted only on an edge where
// the FSM is in IDLE. bin is sampled on that same edge. busy is high while
// a conversion is in flight. bcd_valid pulses for exactly one cycle when
// bcd/blank take their new value. There is no back-pressure and no queuing.
module bin2bcd_seq #(
    parameter int M      = 26,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M-1:0]          bin,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic [DIGITS-1:0]     blank
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0]     LAST_CNT    = CW'(M - 1);
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [W-1:0]        work_q;
    logic [W-1:0]        work_d;
    logic [W-1:0]        corr;
    logic [M-1:0]        sr_q;
    logic [M-1:0]        sr_d;
    logic [CW-1:0]       cnt_q;
    logic [W-1:0]        bcd_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blank_d;
    logic                bcd_valid_q;
    logic                hi_zero;

    // Add-3 correction on every working digit that is 5 or more.
    always_comb begin
        corr = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift {corrected BCD, binary} left by one; binary MSB enters BCD bit 0.
    always_comb begin
        {work_d, sr_d} = {corr, sr_q} << 1;
    end

    // Blank digit i when it and every higher digit are zero; units never blank.
    always_comb begin
        blank_d = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero    = hi_zero & (work_q[4*i +: 4] == 4'd0);
            blank_d[i] = hi_zero;
        end
    end

    // Conversion FSM with all working and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            blank_q     <= BLANK_RESET;
            bcd_valid_q <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= bin;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    sr_q   <= sr_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q       <= work_q;
                    blank_q     <= blank_d;
                    bcd_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd       = bcd_q;
    assign blank     = blank_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed scenarios plus random values,
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int M      = 26;
    localparam int DIGITS = 8;
    localparam int W      = 4 * DIGITS;
    localparam int LAT    = M + 1;
    localparam int BOUND  = 60;

    logic              clk;
    logic              rst;
    logic [M-1:0]      bin;
    logic              start;
    logic [W-1:0]      bcd;
    logic              bcd_valid;
    logic              busy;
    logic [DIGITS-1:0] blank;

    int tests;
    int fails;
    int valid_cnt;

    bin2bcd_seq #(.M(M), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin       (bin),
        .start     (start),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .blank     (blank)
    );

    // Clock and pulse counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial valid_cnt = 0;
    always @(negedge clk) begin
        if (bcd_valid) valid_cnt++;
    end

    // Reference: decimal digits by repeated division.
    function automatic logic [W-1:0] ref_bcd(input longint unsigned v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: digit i blank when the value has no digit at position i.
    function automatic logic [DIGITS-1:0] ref_blank(input longint unsigned v);
        logic [DIGITS-1:0] b;
        longint unsigned p;
        b = '0;
        p = 1;
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            b[i] = (v < p);
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for bcd_valid; returns number of posedges waited (BOUND+1 on timeout).
    task automatic wait_valid(output int edges);
        edges = 0;
        while (edges <= BOUND) begin
            @(posedge clk);
            #1;
            edges++;
            if (bcd_valid === 1'b1) return;
        end
        edges = BOUND + 1;
    endtask

    // Single conversion with full timing and value checks.
    task automatic run_one(input string tag, input logic [M-1:0] v);
        int edges;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, W'(busy), W'(1));
        wait_valid(edges);
        chk({tag, "_lat"}, W'(edges), W'(LAT));
        chk({tag, "_bcd"}, bcd, ref_bcd(longint'(v)));
        chk({tag, "_blank"}, W'(blank), W'(ref_blank(longint'(v))));
        chk({tag, "_busyend"}, W'(busy), W'(0));
        @(posedge clk);
        #1;
        chk({tag, "_pulse1"}, W'(bcd_valid), W'(0));
    endtask

    initial begin
        int edges;
        int vc;
        logic [M-1:0] rv;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_bcd", bcd, '0);
        chk("rst_blank", W'(blank), W'(8'hFE));
        chk("rst_valid", W'(bcd_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));

        // Directed values from the test plan.
        vc = valid_cnt;
        run_one("zero", '0);
        chk("zero_npulse", W'(valid_cnt - vc), W'(1));
        chk("zero_bcd_lit", bcd, 32'h0000_0000);
        run_one("full", M'(67108863));
        chk("full_bcd_lit", bcd, 32'h6710_8863);
        chk("full_blank_lit", W'(blank), W'(8'h00));
        run_one("k1000", M'(1000));
        chk("k1000_blank_lit", W'(blank), W'(8'hF0));
        run_one("nine", M'(9));
        chk("nine_bcd_lit", bcd, 32'h0000_0009);

        // Result holds while idle.
        repeat (20) @(posedge clk);
        #1;
        chk("hold_bcd", bcd, ref_bcd(9));
        chk("hold_valid", W'(valid_cnt - vc), W'(4));

        // Input isolation: new bin and start during SHIFT are ignored.
        @(negedge clk);
        bin   = M'(12345);
        start = 1'b1;
        @(posedge clk);
        #1;
        bin = M'(99);
        wait_valid(edges);
        chk("iso_lat", W'(edges), W'(LAT));
        chk("iso_bcd", bcd, 32'h0001_2345);
        @(posedge clk);
        #1;
        chk("iso_reaccept", W'(busy), W'(1));
        start = 1'b0;
        wait_valid(edges);
        chk("iso2_lat", W'(edges), W'(LAT));
        chk("iso2_bcd", bcd, ref_bcd(99));

        // Back-to-back with start held high; bin steps 1,2,3.
        @(negedge clk);
        bin   = M'(1);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            #1;
            bin = M'(k + 1);
            if (k == 3) start = 1'b0;
            wait_valid(edges);
            chk("b2b_lat", W'(edges), W'(LAT));
            chk("b2b_bcd", bcd, ref_bcd(longint'(k)));
            @(posedge clk);
            if (k < 3) begin
                #1;
                chk("b2b_accept", W'(busy), W'(1));
            end
        end
        #1;
        chk("b2b_idle", W'(busy), W'(0));

        // Reset after 10 shifts aborts with no pulse.
        @(negedge clk);
        bin   = M'(7654321);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vc  = valid_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_bcd", bcd, '0);
        chk("abort_blank", W'(blank), W'(8'hFE));
        chk("abort_valid", W'(bcd_valid), W'(0));
        repeat (40) @(posedge clk);
        #1;
        chk("abort_nopulse", W'(valid_cnt - vc), W'(0));

        // Reset and start together: start dropped.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bin   = M'(5);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rststart_busy", W'(busy), W'(0));
        run_one("after_rst", M'(42));
        chk("after_rst_lit", bcd, 32'h0000_0042);

        // Random values.
        for (int n = 0; n < 12; n++) begin
            rv = M'($urandom_range(0, 67108863));
            run_one("rand", rv);
        end
        for (int n = 0; n < 4; n++) begin
            rv = M'($urandom_range(0, 999));
            run_one("rand_small", rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
